// File: rtl/boxcar_interpolator.sv
// boxcar_interpolator: linear interpolation upsampler by NUM_SAMPLES.
// Each accepted sample produces NUM_SAMPLES outputs stepping from the previous
// input to the current one: o_data = (prev*(L-m) + cur*m) >>> S, m = 1..L.
module boxcar_interpolator #(
  parameter int DATA_WIDTH  = 8,
  parameter int NUM_SAMPLES = 2
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_ce,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_ready,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_ce
);

  localparam int S  = $clog2(NUM_SAMPLES);
  localparam int AW = DATA_WIDTH + S + 1;
  localparam int CW = $clog2(NUM_SAMPLES + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(NUM_SAMPLES - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                r_state, w_state_next;
  logic [DATA_WIDTH-1:0] r_prev, w_prev_next;
  logic [DATA_WIDTH-1:0] r_cur, w_cur_next;
  logic [DATA_WIDTH:0]   r_diff, w_diff_next;
  logic [AW-1:0]         r_acc, w_acc_next;
  logic [CW-1:0]         r_cnt, w_cnt_next;
  logic [DATA_WIDTH-1:0] r_data, w_data_next;
  logic                  r_ce, w_ce_next;

  // Accept-path arithmetic. All sums are modulo 2^AW; the values actually
  // emitted always lie between prev and cur, so wraparound never shows.
  logic [DATA_WIDTH:0] w_diff_in;
  logic [AW-1:0]       w_diff_in_ext;
  logic [AW-1:0]       w_diff_ext;
  logic [AW-1:0]       w_base;
  logic [AW-1:0]       w_m1;
  logic [AW-1:0]       w_m2;
  logic                w_unused;

  assign w_diff_in     = {i_data[DATA_WIDTH-1], i_data} - {r_prev[DATA_WIDTH-1], r_prev};
  assign w_diff_in_ext = {{S{w_diff_in[DATA_WIDTH]}}, w_diff_in};
  assign w_diff_ext    = {{S{r_diff[DATA_WIDTH]}}, r_diff};
  assign w_base        = {r_prev[DATA_WIDTH-1], r_prev, {S{1'b0}}};
  assign w_m1          = w_base + w_diff_in_ext;
  assign w_m2          = w_m1 + w_diff_in_ext;

  // Arithmetic shift by S then truncation to DATA_WIDTH is just a bit slice;
  // the sign bit and fractional bits fall away.
  assign w_unused = ^{w_m1[AW-1], w_m1[S-1:0], r_acc[AW-1], r_acc[S-1:0]};

  assign o_ready = (r_state == IDLE);
  assign o_data  = r_data;
  assign o_ce    = r_ce;

  // State register with synchronous reset; a reset abandons any partial burst.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= IDLE;
      r_prev  <= '0;
      r_cur   <= '0;
      r_diff  <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_data  <= '0;
      r_ce    <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_prev  <= w_prev_next;
      r_cur   <= w_cur_next;
      r_diff  <= w_diff_next;
      r_acc   <= w_acc_next;
      r_cnt   <= w_cnt_next;
      r_data  <= w_data_next;
      r_ce    <= w_ce_next;
    end
  end

  // Next-state: IDLE emits the m=1 sample on accept, RUN steps acc by diff.
  always_comb begin
    w_state_next = r_state;
    w_prev_next  = r_prev;
    w_cur_next   = r_cur;
    w_diff_next  = r_diff;
    w_acc_next   = r_acc;
    w_cnt_next   = r_cnt;
    w_data_next  = r_data;
    w_ce_next    = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_ce) begin
          w_diff_next  = w_diff_in;
          w_data_next  = w_m1[S +: DATA_WIDTH];
          w_ce_next    = 1'b1;
          w_acc_next   = w_m2;
          w_cur_next   = i_data;
          w_cnt_next   = CW'(1);
          w_state_next = RUN;
        end
      end
      RUN: begin
        w_data_next = r_acc[S +: DATA_WIDTH];
        w_ce_next   = 1'b1;
        w_acc_next  = r_acc + w_diff_ext;
        w_cnt_next  = r_cnt + CW'(1);
        if (r_cnt == LAST_CNT) begin
          w_prev_next  = r_cur;
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_boxcar_interpolator.sv
// Directed bench for boxcar_interpolator with L=2 and L=4 instances.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_boxcar_interpolator;

  logic       clk;
  logic       rst2, ce2, rdy2, oce2;
  logic [7:0] d2, od2;
  logic       rst4, ce4, rdy4, oce4;
  logic [7:0] d4, od4;

  int n_checks = 0;
  int n_pass   = 0;

  boxcar_interpolator #(.DATA_WIDTH(8), .NUM_SAMPLES(2)) dut2 (
    .i_clk(clk), .i_reset(rst2), .i_ce(ce2), .i_data(d2),
    .o_ready(rdy2), .o_data(od2), .o_ce(oce2)
  );

  boxcar_interpolator #(.DATA_WIDTH(8), .NUM_SAMPLES(4)) dut4 (
    .i_clk(clk), .i_reset(rst4), .i_ce(ce4), .i_data(d4),
    .o_ready(rdy4), .o_data(od4), .o_ce(oce4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  // One L=2 transaction: present din for one edge, then check both outputs.
  task automatic burst2(input string tag, input int din, input int e1, input int e2);
    ce2 = 1'b1;
    d2  = din[7:0];
    @(negedge clk);
    ce2 = 1'b0;
    check({tag, " ce1"}, int'(oce2), 1);
    check({tag, " d1"}, int'($signed(od2)), e1);
    check({tag, " rdy1"}, int'(rdy2), 0);
    @(negedge clk);
    check({tag, " ce2"}, int'(oce2), 1);
    check({tag, " d2"}, int'($signed(od2)), e2);
    check({tag, " rdy2"}, int'(rdy2), 1);
    $display("L2 %s: in=%0d out=%0d,%0d", tag, din, e1, e2);
  endtask

  // One L=4 transaction; optionally pulses i_ce with 100 during RUN.
  task automatic burst4(input string tag, input int din, input int e0, input int e1,
                        input int e2, input int e3, input bit drop);
    int exp_v[4];
    exp_v[0] = e0; exp_v[1] = e1; exp_v[2] = e2; exp_v[3] = e3;
    ce4 = 1'b1;
    d4  = din[7:0];
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("%s ce%0d", tag, k), int'(oce4), 1);
      check($sformatf("%s d%0d", tag, k), int'($signed(od4)), exp_v[k]);
      check($sformatf("%s rdy%0d", tag, k), int'(rdy4), (k == 3) ? 1 : 0);
      if (drop && k == 0) begin
        ce4 = 1'b1;
        d4  = 8'd100;
      end else begin
        ce4 = 1'b0;
      end
      if (k < 3) @(negedge clk);
    end
    $display("L4 %s: in=%0d out=%0d,%0d,%0d,%0d", tag, din, e0, e1, e2, e3);
  endtask

  task automatic reset2();
    rst2 = 1'b1;
    @(negedge clk);
    rst2 = 1'b0;
  endtask

  task automatic reset4();
    rst4 = 1'b1;
    @(negedge clk);
    rst4 = 1'b0;
  endtask

  initial begin
    rst2 = 1'b1; ce2 = 1'b0; d2 = '0;
    rst4 = 1'b1; ce4 = 1'b0; d4 = '0;
    repeat (2) @(negedge clk);
    rst2 = 1'b0;
    rst4 = 1'b0;
    check("rst2 ce", int'(oce2), 0);
    check("rst2 data", int'($signed(od2)), 0);
    check("rst2 ready", int'(rdy2), 1);
    check("rst4 ce", int'(oce4), 0);
    check("rst4 data", int'($signed(od4)), 0);
    check("rst4 ready", int'(rdy4), 1);

    // L=2 basic and back-to-back, then idle hold.
    burst2("b4", 4, 2, 4);
    burst2("b8", 8, 6, 8);
    @(negedge clk);
    check("idle2 ce", int'(oce2), 0);
    check("idle2 hold", int'($signed(od2)), 8);
    check("idle2 ready", int'(rdy2), 1);

    // Negative floor.
    reset2();
    burst2("neg3", -3, -2, -3);
    burst2("neg4", -4, -4, -4);

    // Full scale swing.
    reset2();
    burst2("fs_lo", -128, -64, -128);
    burst2("fs_hi", 127, -1, 127);

    // Reset wins over a simultaneous i_ce.
    rst2 = 1'b1; ce2 = 1'b1; d2 = 8'd50;
    @(negedge clk);
    rst2 = 1'b0; ce2 = 1'b0;
    check("rstce ce", int'(oce2), 0);
    check("rstce data", int'($signed(od2)), 0);
    check("rstce ready", int'(rdy2), 1);
    @(negedge clk);
    check("rstce idle", int'(oce2), 0);
    burst2("after_rstce", 4, 2, 4);

    // L=4 ramp up and down.
    burst4("up8", 8, 2, 4, 6, 8, 1'b0);
    burst4("down0", 0, 6, 4, 2, 0, 1'b0);

    // Hold and drop: i_ce during RUN is ignored.
    reset4();
    burst4("drop8", 8, 2, 4, 6, 8, 1'b1);
    burst4("next16", 16, 10, 12, 14, 16, 1'b0);

    // Reset mid-burst.
    reset4();
    ce4 = 1'b1; d4 = 8'd8;
    @(negedge clk);
    ce4 = 1'b0;
    check("mid d0", int'($signed(od4)), 2);
    @(negedge clk);
    check("mid d1", int'($signed(od4)), 4);
    rst4 = 1'b1;
    @(negedge clk);
    rst4 = 1'b0;
    check("mid rst ce", int'(oce4), 0);
    check("mid rst data", int'($signed(od4)), 0);
    check("mid rst ready", int'(rdy4), 1);
    burst4("after_mid", 4, 1, 2, 3, 4, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/boxcar_interpolator.md
# boxcar_interpolator

Upsampling counterpart to `boxcar_filter`: accepts one signed sample per low-rate strobe and emits `NUM_SAMPLES` output samples. The output is equivalent to zero-order-hold upsampling by `NUM_SAMPLES` followed by a `NUM_SAMPLES`-tap boxcar average, which amounts to linear interpolation from the previous input to the current one. It sits on the transmit/upsampling side of the DSP chain, feeding higher-rate consumers through the same `i_ce`/`o_ce` strobe convention.

## Interface
- `DATA_WIDTH`, default 8: sample width, two's complement, same width on input and output.
- `NUM_SAMPLES`, default 2: interpolation factor L; a power of two, at least 2. S = log2(L).
- `i_clk`, input, 1: single clock; all logic on the rising edge.
- `i_reset`, input, 1: reset is synchronous and active-high.
- `i_ce`, input, 1: input sample strobe; accepted only while `o_ready`=1.
- `i_data`, input, `DATA_WIDTH`: signed input sample, sampled on accept.
- `o_ready`, output, 1: block can accept an input on this edge.
- `o_data`, output, `DATA_WIDTH`: signed interpolated sample, registered.
- `o_ce`, output, 1: `o_data` valid strobe, registered, one cycle per sample.

## Operation
- State registers:
  - `prev`: last accepted input, reset value 0.
  - `diff`: `cur - prev`, DATA_WIDTH+1 bits, signed.
  - `acc`: signed, DATA_WIDTH+S+1 bits.
  - `cnt`: 0..L.
  - `state`: IDLE or RUN.
- Output definition: for accepted input `cur`, the outputs for m = 1..L are `o_data = (prev*(L-m) + cur*m) >>> S`.
  - The shift is arithmetic, so results floor toward negative infinity.
  - The m=L output equals `cur` exactly.
  - No saturation is needed: every result lies within [min(prev,cur), max(prev,cur)].
- IDLE:
  - `o_ready`=1.
  - If `i_ce`=1: compute `diff = i_data - prev`. Set `o_data <= (prev*L + diff) >>> S`, `o_ce <= 1`, `acc <= prev*L + 2*diff`, `cur <= i_data`, `cnt <= 1`, and go to RUN.
  - Otherwise: `o_ce <= 0` and `o_data` holds its value.
- RUN:
  - `o_ready`=0, and `i_ce` is ignored (the sample is dropped with no side effect).
  - Each edge: `o_data <= acc >>> S`, `o_ce <= 1`, `acc <= acc + diff`, `cnt <= cnt + 1`.
  - On the edge where `cnt` becomes L: `prev <= cur` and go to IDLE.
- `o_ready` is a combinational decode of `state` only; it has no combinational path from `i_ce`.
- Reset:
  - Applies from any state, including mid-RUN. A partial output burst is abandoned.
  - Values: state=IDLE, `prev`=0, `acc`=0, `cnt`=0, `o_data`=0, `o_ce`=0.
  - `o_ready`=1 on the first cycle after the reset edge.

## Timing
- An accept at edge E0 produces `o_ce`=1 after edges E0..E(L-1), i.e. L consecutive cycles. The first sample appears on the cycle following the accept edge (zero extra latency).
- Ready timing: `o_ready` goes low after E0 and returns high after E(L-1). The earliest next accept is edge E(L).
- Maximum throughput is one input per L cycles. When inputs arrive back-to-back at that rate, `o_ce` stays continuously high with no bubble.
- If no input is present in IDLE, `o_ce` is 0 on the following cycle.
- `i_ce` arriving on the same edge as the last RUN output is ignored. The source must hold or re-present the sample until `o_ready`=1.
- Reset asserted on the same edge as `i_ce` takes priority: the input is not accepted.

## Test plan
- L=2, W=8: reset, then input 4 → `o_data` 2, 4 with `o_ce`=1,1. Then input 8 presented at the first `o_ready` → 6, 8 with no `o_ce` gap.
- L=4, W=8: from reset, input 8 → 2, 4, 6, 8. Then input 0 → 6, 4, 2, 0. `o_ready` is low for exactly 3 cycles after each accept.
- Negative floor, L=2: from reset, input -3 → -2, -3. Then input -4 → -4, -4 (because (-7)>>>1 = -4).
- Full-scale, L=2, W=8: input -128, then input 127 → second burst is -1, 127. Also checks `diff`=255 with no overflow.
- Hold and drop, L=4: accept 8, then pulse `i_ce` with 100 during RUN → outputs remain 2, 4, 6, 8 and `prev` stays 8. A later accept of 16 → 10, 12, 14, 16.
- Reset mid-burst, L=4: accept 8, assert `i_reset` after the second output → `o_ce`=0, `o_data`=0, `o_ready`=1. The next input 4 → 1, 2, 3, 4 (`prev` is back to 0).
